seq_restoring_divider: RTL

- Multi-cycle unsigned integer divider: quotient and remainder of two WIDTH-bit operands.
- Restoring algorithm, one quotient bit per clock.
- The trial step is the add/sub datapath held in subtract mode (operand inverted, carry-in 1); its carry-out selects restore or keep.
- Sits beside the parallel add/sub unit in the arithmetic datapath; uses a start/busy/done handshake.

---
 rtl/seq_restoring_divider_pkg.sv | 9 +
 rtl/seq_restoring_divider_if.sv | 23 ++
 rtl/seq_restoring_divider_trial_sub.sv | 14 +
 rtl/seq_restoring_divider.sv | 60 ++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared state encoding and sizing for the sequential divider
package seq_restoring_divider_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  function automatic int cnt_w(input int w);
    return w > 2 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/busy/done handshake and operand/result bundle
interface seq_restoring_divider_if
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master (
    output start, dividend, divisor,
    input busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_trial_sub.sv
// div_trial_sub: one restoring trial step, p - d as invert-and-carry-in addition
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] diff,
  output logic             ge
);
  logic [WIDTH:0] t;
  assign t = {1'b0, p} + {1'b1, ~d} + {{WIDTH{1'b0}}, 1'b1};
  assign diff = t[WIDTH-1:0];
  assign ge = ~t[WIDTH];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring unsigned divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-2:0] p;
  logic [WIDTH-1:0] q, dsr, p_sh, diff, p_nx, q_nx;
  logic ge, last;
  assign p_sh = {p, q[WIDTH-1]};
  assign p_nx = ge ? diff : p_sh;
  assign q_nx = {q[WIDTH-2:0], ge};
  assign last = cnt == '0;
  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .p(p_sh),
    .d(dsr),
    .diff(diff),
    .ge(ge)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_comb bus.busy = state == RUN;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      p <= '0;
      q <= '0;
      dsr <= '0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= state == RUN && last;
      if (state == IDLE) begin
        if (bus.start) begin
          q <= bus.dividend;
          dsr <= bus.divisor;
          p <= '0;
          cnt <= CW'(WIDTH - 1);
        end
      end else begin
        p <= p_nx[WIDTH-2:0];
        q <= q_nx;
        cnt <= last ? '0 : cnt - CW'(1);
        if (last) begin
          bus.quotient <= q_nx;
          bus.remainder <= p_nx;
          bus.div_by_zero <= dsr == '0;
        end
      end
    end
endmodule
